// File: rtl/gmp_demapper_pkg.sv
// Shared types and constants for the GMP demapper and its ds generator.
// ds_ref gives the closed-form data/stuff decision for slot k of a frame.
package gmp_pkg;

  localparam int MPT_W_DEF  = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic ds_ref(input int unsigned k, input int unsigned cm, input int unsigned pm);
    logic r;
    if (pm == 32'd0) begin
      r = 1'b0;
    end else begin
      r = ((k * cm) % pm) < cm;
    end
    return r;
  endfunction

endpackage

// File: rtl/gmp_demapper_ds_gen.sv
// Sigma-delta data/stuff slot generator: one step per slot, ds=1 on data slots.
// Shared with the transmit-side mapper; last flags the pm-th slot of the frame.
module gmp_ds_gen #(
  parameter int MPT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MPT_W-1:0] pm,
  input  logic [MPT_W-1:0] cm,
  output logic             ds,
  output logic             last
);

  // acc stays below pm, so acc + cm fits in MPT_W+1 bits without truncation
  logic [MPT_W:0]   acc_r;
  logic [MPT_W:0]   sum_s;
  logic [MPT_W:0]   acc_nxt_s;
  logic [MPT_W-1:0] slot_cnt_r;

  // data/stuff decision and next accumulator value for the current slot
  always_comb begin
    sum_s     = acc_r + {1'b0, cm};
    ds        = (sum_s >= {1'b0, pm});
    acc_nxt_s = ds ? (sum_s - {1'b0, pm}) : sum_s;
    last      = (slot_cnt_r == pm);
  end

  // accumulator and slot counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r      <= {(MPT_W+1){1'b0}};
      slot_cnt_r <= {MPT_W{1'b0}};
    end else if (load) begin
      acc_r      <= {(MPT_W+1){1'b0}};
      slot_cnt_r <= {{(MPT_W-1){1'b0}}, 1'b1};
    end else if (step) begin
      acc_r      <= acc_nxt_s;
      slot_cnt_r <= last ? slot_cnt_r : (slot_cnt_r + {{(MPT_W-1){1'b0}}, 1'b1});
    end else begin
      acc_r      <= acc_r;
      slot_cnt_r <= slot_cnt_r;
    end
  end

endmodule

// File: rtl/gmp_demapper.sv
// GMP demapper: strips stuff slots from the slot stream and forwards data words.
// Define GMP_DEMAP_ERR_CHECK_EN for early-sof restart and data-count checking.
module gmp_demapper
  import gmp_pkg::*;
#(
  parameter int MPT_W  = MPT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MPT_W-1:0]  pm,
  input  logic [MPT_W-1:0]  cm,
  input  logic              sof,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              sof_out,
  output logic              eof_out,
  output logic              frame_done,
  output logic              err_param,
  output logic              err_sof_early,
  output logic              err_cnt
);

  state_t            state_r, state_s;
  logic [MPT_W-1:0]  pm_r, pm_s, cm_r, cm_s;
  logic [MPT_W-1:0]  data_cnt_r, data_cnt_s, cnt_inc_s;
  logic [DATA_W-1:0] data_out_r, data_out_s;
  logic              dv_r, dv_s, sof_o_r, sof_o_s, eof_o_r, eof_o_s, fd_r, fd_s;
  logic              errp_r, errp_s, errs_r, errs_s, errc_r, errc_s;
  logic              load_s, step_s, ds_s, last_s, hdr_ok_s, restart_s;

  gmp_ds_gen #(.MPT_W(MPT_W)) u_ds_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .step (step_s),
    .pm   (pm_r),
    .cm   (cm_r),
    .ds   (ds_s),
    .last (last_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    pm_s       = pm_r;
    cm_s       = cm_r;
    data_cnt_s = data_cnt_r;
    data_out_s = data_out_r;
    dv_s       = 1'b0;
    sof_o_s    = 1'b0;
    eof_o_s    = 1'b0;
    fd_s       = 1'b0;
    errp_s     = 1'b0;
    errs_s     = 1'b0;
    errc_s     = 1'b0;
    load_s     = 1'b0;
    step_s     = 1'b0;
    hdr_ok_s   = (pm != {MPT_W{1'b0}}) && (cm <= pm);
    cnt_inc_s  = data_cnt_r + {{(MPT_W-1){1'b0}}, 1'b1};
`ifdef GMP_DEMAP_ERR_CHECK_EN
    restart_s  = sof;
`else
    restart_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (sof) begin
          if (hdr_ok_s) begin
            load_s = 1'b1;
          end else begin
            errp_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (restart_s) begin
          errs_s = 1'b1;
          if (hdr_ok_s) begin
            load_s = 1'b1;
          end else begin
            errp_s  = 1'b1;
            state_s = IDLE;
          end
        end else if (valid_in) begin
          step_s = 1'b1;
          if (ds_s) begin
            data_out_s = data_in;
            dv_s       = 1'b1;
            sof_o_s    = (data_cnt_r == {MPT_W{1'b0}});
            eof_o_s    = (cnt_inc_s == cm_r);
            data_cnt_s = cnt_inc_s;
          end else begin
            data_cnt_s = data_cnt_r;
          end
          if (last_s) begin
            fd_s    = 1'b1;
            state_s = IDLE;
`ifdef GMP_DEMAP_ERR_CHECK_EN
            errc_s  = ((ds_s ? cnt_inc_s : data_cnt_r) != cm_r);
`else
            errc_s  = 1'b0;
`endif
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // a new header is latched from whichever branch accepted it
    if (load_s) begin
      pm_s       = pm;
      cm_s       = cm;
      data_cnt_s = {MPT_W{1'b0}};
      state_s    = RUN;
    end else begin
      pm_s = pm_r;
    end
  end

  // state and registered outputs; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pm_r       <= {MPT_W{1'b0}};
      cm_r       <= {MPT_W{1'b0}};
      data_cnt_r <= {MPT_W{1'b0}};
      data_out_r <= {DATA_W{1'b0}};
      dv_r       <= 1'b0;
      sof_o_r    <= 1'b0;
      eof_o_r    <= 1'b0;
      fd_r       <= 1'b0;
      errp_r     <= 1'b0;
      errs_r     <= 1'b0;
      errc_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pm_r       <= pm_s;
      cm_r       <= cm_s;
      data_cnt_r <= data_cnt_s;
      data_out_r <= data_out_s;
      dv_r       <= dv_s;
      sof_o_r    <= sof_o_s;
      eof_o_r    <= eof_o_s;
      fd_r       <= fd_s;
      errp_r     <= errp_s;
      errs_r     <= errs_s;
      errc_r     <= errc_s;
    end
  end

  assign data_out      = data_out_r;
  assign data_valid    = dv_r;
  assign sof_out       = sof_o_r;
  assign eof_out       = eof_o_r;
  assign frame_done    = fd_r;
  assign err_param     = errp_r;
  assign err_sof_early = errs_r;
  assign err_cnt       = errc_r;

endmodule
